// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//
// Streams the full contents of the register file as (address, data) beats.
// A start pulse launches a walk over the registers, two at a time: one READ
// cycle drives both combinational read ports and captures the pair into local
// buffers, then the two buffered beats go out over a valid/ready handshake.
// The write path of the register file is never touched.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 single-cycle dump request (ignored while busy)
//   Rs1 / Rs2             read addresses (even / odd register of the pair),
//                         zero outside the READ cycle
//   read_data1/2          combinational read data for Rs1 / Rs2
//   out_valid/out_ready   output beat handshake
//   out_addr/out_data     register index and contents of the current beat
//   out_last              current beat is register NUM_REGS-1
//   busy                  dump in progress
//   done                  one-cycle pulse after the final beat is accepted
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] Rs1,
    output logic [ADDR_W-1:0] Rs2,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int                NUM_PAIRS = NUM_REGS / 2;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_PAIRS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SEND0,
        S_SEND1,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_next;
    logic [DATA_W-1:0] buf0;
    logic [DATA_W-1:0] buf1;
    logic [ADDR_W-1:0] even_addr;
    logic [ADDR_W-1:0] odd_addr;
    logic              last_pair;

    assign even_addr = idx << 1;
    assign odd_addr  = even_addr | ADDR_W'(1);
    assign last_pair = (idx == LAST_IDX);

    // State, pair index and pair buffers. The buffers load only in READ, so
    // a pair is a snapshot of the file taken in exactly that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
            buf0  <= '0;
            buf1  <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (state == S_READ) begin
                buf0 <= read_data1;
                buf1 <= read_data2;
            end
        end
    end

    // Next state and outputs; outputs depend only on registered state, idx
    // and buffers, never on start or out_ready.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        Rs1        = '0;
        Rs2        = '0;
        out_valid  = 1'b0;
        out_addr   = '0;
        out_data   = '0;
        out_last   = 1'b0;
        busy       = (state != S_IDLE);
        done       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_READ;
                    idx_next   = '0;
                end
            end
            S_READ: begin
                Rs1        = even_addr;
                Rs2        = odd_addr;
                state_next = S_SEND0;
            end
            S_SEND0: begin
                out_valid = 1'b1;
                out_addr  = even_addr;
                out_data  = buf0;
                if (out_ready) begin
                    state_next = S_SEND1;
                end
            end
            S_SEND1: begin
                out_valid = 1'b1;
                out_addr  = odd_addr;
                out_data  = buf1;
                out_last  = last_pair;
                if (out_ready) begin
                    if (last_pair) begin
                        state_next = S_DONE;
                    end else begin
                        idx_next   = idx + ADDR_W'(1);
                        state_next = S_READ;
                    end
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader
//
// Directed bench for regfile_dump_reader. A 32x32 register file model sits
// behind the read ports. Inputs are driven and outputs sampled at the falling
// edge; cycle k of a dump is the k-th falling edge after the start pulse.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  Rs1, Rs2;
    logic [31:0] read_data1, read_data2;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] rf [32];

    int n_cmp  = 0;
    int n_fail = 0;

    // results of the most recent run_dump
    logic [4:0]  b_addr [64];
    logic [31:0] b_data [64];
    logic        b_last [64];
    int          b_cyc  [64];
    int          n_beats, done_cyc, n_done;
    int          stall_err, rs_err, busy_err;
    bit          timed_out, snap_done;
    logic        busy_after, done_after;

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .Rs1(Rs1), .Rs2(Rs2),
        .read_data1(read_data1), .read_data2(read_data2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    assign read_data1 = rf[Rs1];
    assign read_data2 = rf[Rs2];

    always #5 clk = ~clk;

    // Pulses start and runs one dump, recording beats and protocol errors.
    // ready_mode 0: ready always high; 1: ready pattern 1,0,0,1 repeating.
    // snap_en: in SEND0 of pair 8 write reg 17 and reg 20.
    task automatic run_dump(input int ready_mode, input bit snap_en, input int max_cyc);
        bit          prev_stall;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        pl;
        for (int i = 0; i < 64; i++) begin
            b_addr[i] = 'x; b_data[i] = 'x; b_last[i] = 1'bx; b_cyc[i] = -1;
        end
        n_beats = 0; done_cyc = -1; n_done = 0;
        stall_err = 0; rs_err = 0; busy_err = 0;
        timed_out = 1'b1; snap_done = 1'b0;
        busy_after = 1'bx; done_after = 1'bx;
        prev_stall = 1'b0; pa = '0; pd = '0; pl = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            start = 1'b0;
            out_ready = (ready_mode == 0) ? 1'b1 : ((k % 4 == 1) || (k % 4 == 0));
            if (snap_en && !snap_done && out_valid && out_addr == 5'd16) begin
                rf[17] = 32'hDEADBEEF;
                rf[20] = 32'hCAFEF00D;
                snap_done = 1'b1;
            end
            if (prev_stall && (out_valid !== 1'b1 || out_addr !== pa ||
                               out_data !== pd || out_last !== pl))
                stall_err++;
            if (busy && !out_valid && !done) begin
                if (Rs1 !== 5'(n_beats) || Rs2 !== 5'(n_beats + 1)) rs_err++;
            end else if (Rs1 !== 5'd0 || Rs2 !== 5'd0) begin
                rs_err++;
            end
            if (done_cyc < 0 && busy !== 1'b1) busy_err++;
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (out_valid && out_ready) begin
                if (n_beats < 64) begin
                    b_addr[n_beats] = out_addr;
                    b_data[n_beats] = out_data;
                    b_last[n_beats] = out_last;
                    b_cyc[n_beats]  = k;
                end
                n_beats++;
            end
            prev_stall = out_valid && !out_ready;
            pa = out_addr; pd = out_data; pl = out_last;
            if (done_cyc >= 0) begin
                @(negedge clk);
                busy_after = busy;
                done_after = done;
                timed_out  = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [79:0] outs;
        repeat (2) @(negedge clk);
        outs = {Rs1, Rs2, out_valid, out_addr, out_data, out_last, busy, done, 3'b0, out_data};
        n_cmp++;
        if (outs !== 80'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            outs = {Rs1, Rs2, out_valid, out_addr, out_data, out_last, busy, done, 3'b0, out_data};
            n_cmp++;
            if (outs !== 80'd0) begin
                n_fail++;
                $display("FAIL idle_outputs[%0d]: got %h want 0", c, outs);
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] exp_d;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[16] = 32'hA5A5A5A5;
        run_dump(0, 1'b0, 200);
        n_cmp++;
        if (timed_out || n_beats != 32) begin
            n_fail++;
            $display("FAIL single_beats: got %0d (timeout %0d) want 32", n_beats, timed_out);
        end
        for (int i = 0; i < 32; i++) begin
            exp_d = (i == 16) ? 32'hA5A5A5A5 : 32'd0;
            n_cmp++;
            if (b_addr[i] !== 5'(i) || b_data[i] !== exp_d || b_last[i] !== (i == 31)) begin
                n_fail++;
                $display("FAIL single_beat[%0d]: got addr %0d data %h last %b want addr %0d data %h last %b",
                         i, b_addr[i], b_data[i], b_last[i], i, exp_d, (i == 31));
            end
            n_cmp++;
            if (b_cyc[i] != (i / 2) * 3 + 2 + (i % 2)) begin
                n_fail++;
                $display("FAIL single_timing[%0d]: got cycle %0d want %0d", i, b_cyc[i], (i / 2) * 3 + 2 + (i % 2));
            end
        end
        n_cmp++;
        if (done_cyc != 49 || n_done != 1) begin
            n_fail++;
            $display("FAIL single_done: got cycle %0d count %0d want cycle 49 count 1", done_cyc, n_done);
        end
        n_cmp++;
        if (busy_err != 0 || busy_after !== 1'b0 || done_after !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy: got errs %0d busy_after %b done_after %b want 0 0 0",
                     busy_err, busy_after, done_after);
        end
        n_cmp++;
        if (rs_err != 0) begin
            n_fail++;
            $display("FAIL single_rs: got %0d bad cycles want 0", rs_err);
        end
    endtask

    task automatic test_full_pattern();
        rf[0] = 32'd0;
        for (int i = 1; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
        run_dump(0, 1'b0, 200);
        n_cmp++;
        if (timed_out || n_beats != 32) begin
            n_fail++;
            $display("FAIL full_beats: got %0d want 32", n_beats);
        end
        for (int i = 1; i < 32; i++) begin
            n_cmp++;
            if (b_addr[i] !== 5'(i) || b_data[i] !== 32'h1000_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL full_beat[%0d]: got addr %0d data %h want addr %0d data %h",
                         i, b_addr[i], b_data[i], i, 32'h1000_0000 + 32'(i));
            end
        end
        n_cmp++;
        if (rs_err != 0) begin
            n_fail++;
            $display("FAIL full_rs: got %0d bad cycles want 0", rs_err);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 32; i++) rf[i] = 32'h3000_0000 + 32'(i) * 32'h0101;
        run_dump(1, 1'b0, 400);
        n_cmp++;
        if (timed_out || n_beats != 32 || n_done != 1) begin
            n_fail++;
            $display("FAIL bp_beats: got %0d beats %0d done want 32 beats 1 done", n_beats, n_done);
        end
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (b_addr[i] !== 5'(i) || b_data[i] !== 32'h3000_0000 + 32'(i) * 32'h0101 ||
                b_last[i] !== (i == 31)) begin
                n_fail++;
                $display("FAIL bp_beat[%0d]: got addr %0d data %h last %b want addr %0d data %h",
                         i, b_addr[i], b_data[i], b_last[i], i, 32'h3000_0000 + 32'(i) * 32'h0101);
            end
        end
        n_cmp++;
        if (stall_err != 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stall_err);
        end
        n_cmp++;
        if (rs_err != 0 || busy_err != 0) begin
            n_fail++;
            $display("FAIL bp_ctrl: got rs errs %0d busy errs %0d want 0 0", rs_err, busy_err);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_snapshot();
        for (int i = 0; i < 32; i++) rf[i] = 32'h2000_0000 + 32'(i);
        run_dump(0, 1'b1, 200);
        n_cmp++;
        if (!snap_done || timed_out || n_beats != 32) begin
            n_fail++;
            $display("FAIL snap_run: got snap %0d beats %0d want 1 32", snap_done, n_beats);
        end
        n_cmp++;
        if (b_addr[17] !== 5'd17 || b_data[17] !== 32'h2000_0011) begin
            n_fail++;
            $display("FAIL snap_reg17: got addr %0d data %h want 17 20000011", b_addr[17], b_data[17]);
        end
        n_cmp++;
        if (b_addr[20] !== 5'd20 || b_data[20] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL snap_reg20: got addr %0d data %h want 20 cafef00d", b_addr[20], b_data[20]);
        end
        n_cmp++;
        if (b_data[16] !== 32'h2000_0010 || b_data[21] !== 32'h2000_0015) begin
            n_fail++;
            $display("FAIL snap_neighbours: got %h %h want 20000010 20000015", b_data[16], b_data[21]);
        end
    endtask

    task automatic test_back_to_back();
        int  k2;
        bit  seen;
        for (int i = 0; i < 32; i++) rf[i] = 32'h5000_0000 + 32'(i);
        run_dump(0, 1'b0, 200);
        // now in cycle E+50: start here must be accepted
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || Rs1 !== 5'd0 || Rs2 !== 5'd1) begin
            n_fail++;
            $display("FAIL b2b_restart: got busy %b Rs1 %0d Rs2 %0d want 1 0 1", busy, Rs1, Rs2);
        end
        seen = 1'b0;
        k2 = 0;
        for (int k = 2; k <= 80; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                k2 = k;
                break;
            end
        end
        n_cmp++;
        if (!seen || k2 != 49) begin
            n_fail++;
            $display("FAIL b2b_done: got seen %0d cycle %0d want 1 49", seen, k2);
        end
        @(negedge clk);
    endtask

    task automatic test_midreset();
        int  nb;
        bit  hit;
        bit  done_seen;
        logic [79:0] outs;
        for (int i = 0; i < 32; i++) rf[i] = 32'h4000_0000 + 32'(i);
        out_ready = 1'b1;
        nb = 0; hit = 1'b0; done_seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) done_seen = 1'b1;
            if (out_valid && out_addr == 5'd10) begin
                reset = 1'b1;
                hit = 1'b1;
                break;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (out_addr !== 5'(nb) || b_cyc[0] < -1 ||
                    k != (nb / 2) * 3 + 2 + (nb % 2)) begin
                    n_fail++;
                    $display("FAIL midreset_beat[%0d]: got addr %0d cycle %0d want addr %0d cycle %0d",
                             nb, out_addr, k, nb, (nb / 2) * 3 + 2 + (nb % 2));
                end
                if (nb == 5) start = 1'b1;
                nb++;
            end
        end
        n_cmp++;
        if (!hit || nb != 10) begin
            n_fail++;
            $display("FAIL midreset_reach: got hit %0d beats %0d want 1 10", hit, nb);
        end
        @(negedge clk);
        outs = {Rs1, Rs2, out_valid, out_addr, out_data, out_last, busy, done, 3'b0, out_data};
        n_cmp++;
        if (outs !== 80'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h want 0", outs);
        end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
        end
        n_cmp++;
        if (done_seen) begin
            n_fail++;
            $display("FAIL midreset_nodone: got activity after reset want none");
        end
        run_dump(0, 1'b0, 200);
        n_cmp++;
        if (timed_out || n_beats != 32 || b_addr[0] !== 5'd0 || b_cyc[0] != 2 ||
            b_data[0] !== 32'h4000_0000 || done_cyc != 49) begin
            n_fail++;
            $display("FAIL midreset_restart: got beats %0d addr0 %0d cyc0 %0d data0 %h done %0d want 32 0 2 40000000 49",
                     n_beats, b_addr[0], b_cyc[0], b_data[0], done_cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        test_reset();
        test_single();
        test_full_pattern();
        test_backpressure();
        test_snapshot();
        test_back_to_back();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential read-side companion to the 32×32 register file. On a start pulse it walks every architectural register through the file's two combinational read ports, two registers per read cycle, and streams each (address, data) pair out over a valid/ready handshake. It sits beside the register file in the single-cycle RISC-V core and gives debug and verification logic a full register dump without touching the write path (RegWrite/Rd/Write_data).

## Interface
- NUM_REGS, 32, registers dumped; even, ≥2
- ADDR_W, 5, register address width; 2^ADDR_W ≥ NUM_REGS
- DATA_W, 32, register data width

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a dump
- Rs1  output  ADDR_W  register file read address, port 1 (even registers)
- Rs2  output  ADDR_W  register file read address, port 2 (odd registers)
- read_data1  input  DATA_W  register file data for Rs1, combinational
- read_data2  input  DATA_W  register file data for Rs2, combinational
- out_valid  output  1  output beat valid
- out_ready  input  1  consumer accepts beat
- out_addr  output  ADDR_W  register index of current beat
- out_data  output  DATA_W  register contents of current beat
- out_last  output  1  current beat is register NUM_REGS-1
- busy  output  1  dump in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse after the final beat is accepted

## Operation
- States: IDLE, READ, SEND0, SEND1, DONE. Pair index `idx` runs 0..NUM_REGS/2-1.
- IDLE: start=1 → READ, idx←0. start=0 → stay.
- READ: Rs1=2·idx, Rs2=2·idx+1. Latch read_data1→buf0 and read_data2→buf1 at the clock edge. Always → SEND0.
- SEND0: out_valid=1, out_addr=2·idx, out_data=buf0. out_ready=1 → SEND1.
- SEND1: out_valid=1, out_addr=2·idx+1, out_data=buf1, out_last=1 iff idx=NUM_REGS/2-1. out_ready=1 → DONE if last pair, otherwise idx←idx+1 and → READ.
- DONE: done=1 → IDLE.
- Rs1/Rs2 are 0 outside READ. out_addr, out_data, and out_last are 0 when out_valid=0.
- Data is passed through unmodified. x0 is not forced to zero; the reader reports whatever the file returns.
- Snapshot semantics: each pair is sampled only in its READ cycle. A register write after that cycle does not affect the beats already buffered. A write before the pair's READ cycle is reflected in the dump.
- start while busy=1 is ignored. No queuing.
- reset: next state IDLE, idx=0, buf0/buf1=0, all outputs 0. Reset mid-dump abandons it with no done pulse.

## Timing
- Reset values: Rs1=0, Rs2=0, out_valid=0, out_addr=0, out_data=0, out_last=0, busy=0, done=0.
- All outputs are decoded from registered state, idx, and buffers. There is no combinational path from out_ready or start to any output.
- start sampled high at edge E: READ during cycle E+1. First beat (addr 0) is valid in cycle E+2.
- With out_ready held high, each pair takes 3 cycles (READ, SEND0, SEND1):
  - last beat (addr 31) at cycle E+48
  - done=1 in cycle E+49
  - busy=0 and a new start is accepted from cycle E+50
- Backpressure: while out_valid=1 and out_ready=0, out_addr, out_data, and out_last hold stable. A beat completes only on an edge where out_valid and out_ready are both high.
- busy is high from cycle E+1 through the DONE cycle inclusive.

## Test plan
- Reset then idle: assert reset for 2 cycles, start=0 for 10 cycles → every output stays 0 and Rs1=Rs2=0.
- Single value: write 32'hA5A5A5A5 to register 16, then pulse start with out_ready=1 → 32 beats with addr 0..31 in order; beat addr 16 carries A5A5A5A5. out_last is high only on addr 31. done pulses in cycle E+49.
- Full pattern: preload reg i = 32'h1000_0000+i (i=1..31), then dump → every beat has out_data = 1000_0000+out_addr for i≥1. Rs1/Rs2 equal (2k, 2k+1) only in READ cycles.
- Backpressure: toggle out_ready 1,0,0,1 repeatedly → no beat lost or duplicated, data stable while stalled, total of 32 accepted beats.
- Snapshot: during SEND0 of pair idx=8, write 32'hDEADBEEF to reg 17 → beat addr 17 shows the old value. A write to reg 20 in the same cycle does appear at addr 20.
- Reset mid-dump / start while busy: pulse start again at beat 5 → ignored and the sequence continues. Assert reset at beat 10 → IDLE next cycle, no done pulse, outputs 0. A new start then restarts the dump at addr 0.
